// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - UART byte-stream framer producing register read/write requests
// Frames: SYNC, CMD, REG, DATA, CHK (CHK = CMD ^ REG ^ DATA); errors reported as 1-cycle pulses.
module uart_cmd_parser #(
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic       clk_in,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       cmd_ready,
   output logic       cmd_valid,
   output logic       cmd_rw,
   output logic [7:0] cmd_reg,
   output logic [7:0] cmd_wdata,
   output logic       busy,
   output logic       err_checksum,
   output logic       err_format,
   output logic       err_timeout,
   output logic       err_overrun
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   // Counter holds completed silent cycles; the last one expires the frame.
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {S_IDLE, S_CMD, S_REG, S_DATA, S_CHK, S_ISSUE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    acc_q, acc_d;
   logic          rw_q, rw_d;
   logic [7:0]    reg_q, reg_d;
   logic [7:0]    wdata_q, wdata_d;
   logic          valid_q, busy_q;
   logic          ecs_q, ecs_d, efmt_q, efmt_d, eto_q, eto_d, eovr_q, eovr_d;
   logic          in_frame;

   assign in_frame = (state_q == S_CMD) || (state_q == S_REG) ||
                     (state_q == S_DATA) || (state_q == S_CHK);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      rw_d    = rw_q;
      reg_d   = reg_q;
      wdata_d = wdata_q;
      ecs_d   = 1'b0;
      efmt_d  = 1'b0;
      eto_d   = 1'b0;
      eovr_d  = 1'b0;

      if (in_frame) begin
         if (rx_valid) begin
            cnt_d = '0;
         end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            eto_d   = 1'b1;
            state_d = S_IDLE;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end

      case (state_q)
         S_IDLE: begin
            if (rx_valid && rx_data == SYNC_BYTE) begin
               state_d = S_CMD;
               cnt_d   = '0;
               acc_d   = 8'h00;
            end
         end
         S_CMD: begin
            if (rx_valid) begin
               if (rx_data[7:1] == 7'd0) begin
                  rw_d    = rx_data[0];
                  acc_d   = acc_q ^ rx_data;
                  state_d = S_REG;
               end else begin
                  efmt_d  = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         S_REG: begin
            if (rx_valid) begin
               reg_d   = rx_data;
               acc_d   = acc_q ^ rx_data;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (rx_valid) begin
               wdata_d = rx_data;
               acc_d   = acc_q ^ rx_data;
               state_d = S_CHK;
            end
         end
         S_CHK: begin
            if (rx_valid) begin
               if (rx_data == acc_q) begin
                  state_d = S_ISSUE;
               end else begin
                  ecs_d   = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         S_ISSUE: begin
            // Request fields are frozen here; incoming bytes are dropped.
            if (rx_valid) eovr_d = 1'b1;
            if (cmd_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         acc_q   <= 8'h00;
         rw_q    <= 1'b0;
         reg_q   <= 8'h00;
         wdata_q <= 8'h00;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         ecs_q   <= 1'b0;
         efmt_q  <= 1'b0;
         eto_q   <= 1'b0;
         eovr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         rw_q    <= rw_d;
         reg_q   <= reg_d;
         wdata_q <= wdata_d;
         valid_q <= (state_d == S_ISSUE);
         busy_q  <= (state_d != S_IDLE);
         ecs_q   <= ecs_d;
         efmt_q  <= efmt_d;
         eto_q   <= eto_d;
         eovr_q  <= eovr_d;
      end
   end

   assign cmd_valid    = valid_q;
   assign cmd_rw       = rw_q;
   assign cmd_reg      = reg_q;
   assign cmd_wdata    = wdata_q;
   assign busy         = busy_q;
   assign err_checksum = ecs_q;
   assign err_format   = efmt_q;
   assign err_timeout  = eto_q;
   assign err_overrun  = eovr_q;
endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Byte-level command framer that sits directly downstream of the UART receiver in the MPU6050 bridge. It consumes the receiver's per-byte data/valid pulses and assembles fixed 5-byte host frames: sync, command, register, data, checksum. It validates each frame and presents one register read/write request to the I2C master-side controller over a valid/ready handshake. Malformed, stalled, and overrun input is reported on one-cycle error pulses.

## Interface
- SYNC_BYTE, 8'hA5, frame start marker
- TIMEOUT_CYCLES, 100000, maximum idle clocks allowed between bytes inside a frame; must be ≥2
- clk_in  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- rx_data  input  8  received byte, meaningful only when rx_valid=1
- rx_valid  input  1  one-cycle pulse per received byte
- cmd_ready  input  1  downstream accepts the request
- cmd_valid  output  1  request pending
- cmd_rw  output  1  0=write, 1=read
- cmd_reg  output  8  MPU6050 register address
- cmd_wdata  output  8  write data (frame DATA byte, passed through for reads too)
- busy  output  1  high in any state other than IDLE
- err_checksum  output  1  one-cycle pulse: checksum mismatch
- err_format  output  1  one-cycle pulse: illegal command byte
- err_timeout  output  1  one-cycle pulse: inter-byte timeout
- err_overrun  output  1  one-cycle pulse: byte dropped while a request is pending

## Operation
- Frame format: SYNC_BYTE, CMD, REG, DATA, CHK, with CHK = CMD ^ REG ^ DATA.
- Legal CMD values are 8'h00 (write) and 8'h01 (read). CMD[7:1]≠0 is illegal.
- States: IDLE, CMD, REG, DATA, CHK, ISSUE.
- IDLE: a byte equal to SYNC_BYTE → CMD. Any other byte is silently ignored.
- CMD: a legal byte latches rw and goes → REG. An illegal byte pulses err_format and goes → IDLE.
- REG: latch the byte into cmd_reg and go → DATA.
- DATA: latch the byte into cmd_wdata and go → CHK.
- CHK: on a match, go → ISSUE. On a mismatch, pulse err_checksum and go → IDLE; no request is issued.
- Inside a frame, a SYNC_BYTE value is ordinary data. There is no resync.
- ISSUE: cmd_valid=1. cmd_rw, cmd_reg and cmd_wdata stay stable until the handshake.
  - On cmd_valid & cmd_ready → IDLE.
  - Any rx_valid while in ISSUE, including on the handshake cycle, is dropped and pulses err_overrun.
- Timeout counter:
  - Runs only in CMD, REG, DATA and CHK.
  - Clears on entry to CMD and on every accepted byte.
  - Width is $clog2(TIMEOUT_CYCLES+1).
  - When it reaches TIMEOUT_CYCLES without a byte: → IDLE and pulse err_timeout.
  - If rx_valid coincides with expiry, the byte is accepted and no timeout occurs.
- Running XOR accumulator: cleared on entering CMD; updated with the CMD, REG and DATA bytes.
- Reset, including mid-frame or mid-ISSUE: state=IDLE; all outputs, counter and accumulator return to 0; any partial frame or pending request is discarded.

## Timing
- All outputs are registered.
- Reset values: cmd_valid=0, cmd_rw=0, cmd_reg=8'h00, cmd_wdata=8'h00, busy=0, all err_*=0.
- Latency: cmd_valid rises on the clock edge that samples the valid CHK byte, i.e. visible 1 cycle after the rx_valid cycle.
- cmd_valid falls on the edge after the handshake cycle. The next frame's SYNC is accepted from that cycle onward.
- Error pulses are exactly 1 cycle long and asserted on the edge that samples the offending byte or timeout. busy falls on that same edge.
- Back-to-back rx_valid on consecutive cycles must be accepted without loss, in every state except ISSUE.
- cmd_ready is ignored while cmd_valid=0.

## Test plan
- Write frame: A5 00 6B 00 6B with cmd_ready=1 → one cmd_valid cycle, rw=0, reg=8'h6B, wdata=8'h00. No errors; busy low afterwards.
- Read frame: A5 01 3B 00 3A → rw=1, reg=8'h3B. Hold cmd_ready=0 for 10 cycles → cmd_valid and fields stable for all 10. Raise cmd_ready → cmd_valid falls next cycle.
- Overrun: inject byte 8'h55 during the stalled ISSUE → one err_overrun pulse, request fields unchanged.
- Errors:
  - A5 00 6B 00 6A → err_checksum once, cmd_valid never asserts.
  - A5 02 … → err_format on the CMD byte.
  - Noise 12 34 before A5 is ignored.
- Timeout (TIMEOUT_CYCLES=20):
  - A5 00, then 20 silent cycles → err_timeout, IDLE. A following full valid frame is accepted normally.
  - A byte landing exactly on cycle 20 → accepted, no timeout.
- Reset: assert rst after A5 00 6B, and separately during ISSUE → outputs go to reset values immediately. A subsequent frame A5 01 75 00 74 yields reg=8'h75, rw=1.
